// File: rtl/fc_neuron_sequencer_if.sv
// Handshake and memory-port bundle between the fully-connected neuron sequencer
// and its surrounding layer datapath (memories, MAC accumulator, neighbour layers).
interface fc_neuron_sequencer_if #(
  parameter int IFM_ADDR_BITS = 7,
  parameter int WM_ADDR_BITS  = 14,
  parameter int OFM_ADDR_BITS = 7
);
  logic                     start_from_previous;
  logic                     end_to_previous;
  logic                     start_to_next;
  logic                     end_from_next;
  logic                     ifm_enable_read;
  logic [IFM_ADDR_BITS-1:0] ifm_address_read;
  logic                     wm_enable_read;
  logic [WM_ADDR_BITS-1:0]  wm_address_read;
  logic                     bias_enable_read;
  logic [OFM_ADDR_BITS-1:0] bias_address_read;
  logic                     acc_clear;
  logic                     acc_enable;
  logic                     bias_add;
  logic                     ofm_enable_write;
  logic [OFM_ADDR_BITS-1:0] ofm_address_write;
  logic                     busy;

  modport master (
    input  start_from_previous, end_from_next,
    output end_to_previous, start_to_next,
    output ifm_enable_read, ifm_address_read,
    output wm_enable_read, wm_address_read,
    output bias_enable_read, bias_address_read,
    output acc_clear, acc_enable, bias_add,
    output ofm_enable_write, ofm_address_write,
    output busy
  );

  modport slave (
    output start_from_previous, end_from_next,
    input  end_to_previous, start_to_next,
    input  ifm_enable_read, ifm_address_read,
    input  wm_enable_read, wm_address_read,
    input  bias_enable_read, bias_address_read,
    input  acc_clear, acc_enable, bias_add,
    input  ofm_enable_write, ofm_address_write,
    input  busy
  );
endinterface

// File: rtl/fc_neuron_sequencer.sv
// Control FSM for one fully-connected layer: per neuron it clears the accumulator,
// streams IFM_DEPTH input/weight pairs, adds the bias and writes the output feature.
module fc_neuron_sequencer #(
  parameter int IFM_DEPTH         = 120,
  parameter int NUMBER_OF_NEURONS = 84,
  parameter int IFM_ADDR_BITS     = $clog2(IFM_DEPTH),
  parameter int WM_ADDR_BITS      = $clog2(IFM_DEPTH*NUMBER_OF_NEURONS),
  parameter int OFM_ADDR_BITS     = $clog2(NUMBER_OF_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  fc_neuron_sequencer_if.master seq
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_BIAS, S_ADD, S_WRITE, S_DONE, S_WAIT_NEXT
  } state_t;

  localparam logic [IFM_ADDR_BITS-1:0] LAST_I = IFM_ADDR_BITS'(IFM_DEPTH - 1);
  localparam logic [OFM_ADDR_BITS-1:0] LAST_N = OFM_ADDR_BITS'(NUMBER_OF_NEURONS - 1);
  localparam logic [IFM_ADDR_BITS-1:0] I_ONE  = IFM_ADDR_BITS'(1);
  localparam logic [WM_ADDR_BITS-1:0]  W_ONE  = WM_ADDR_BITS'(1);
  localparam logic [OFM_ADDR_BITS-1:0] N_ONE  = OFM_ADDR_BITS'(1);

  state_t                   r_state, w_state_next;
  logic [IFM_ADDR_BITS-1:0] r_i, w_i_next;
  logic [WM_ADDR_BITS-1:0]  r_w, w_w_next;
  logic [OFM_ADDR_BITS-1:0] r_n, w_n_next;
  logic                     r_acc_enable;

  logic w_mac_read;
  logic w_acc_clear;
  logic w_bias_read;
  logic w_bias_add;
  logic w_ofm_write;
  logic w_start_to_next;
  logic w_end_to_previous;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_w          <= '0;
      r_n          <= '0;
      r_acc_enable <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_i          <= w_i_next;
      r_w          <= w_w_next;
      r_n          <= w_n_next;
      // Memories answer one cycle after the read, so accumulate one cycle later.
      r_acc_enable <= w_mac_read;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_i_next          = r_i;
    w_w_next          = r_w;
    w_n_next          = r_n;
    w_mac_read        = 1'b0;
    w_acc_clear       = 1'b0;
    w_bias_read       = 1'b0;
    w_bias_add        = 1'b0;
    w_ofm_write       = 1'b0;
    w_start_to_next   = 1'b0;
    w_end_to_previous = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_end_to_previous = 1'b1;
        if (seq.start_from_previous) begin
          w_state_next = S_CLEAR;
          w_n_next     = '0;
          w_w_next     = '0;
        end
      end
      S_CLEAR: begin
        w_acc_clear  = 1'b1;
        w_i_next     = '0;
        w_state_next = S_MAC;
      end
      S_MAC: begin
        // The weight counter runs on across neurons; only the input index wraps.
        w_mac_read = 1'b1;
        w_w_next   = r_w + W_ONE;
        if (r_i == LAST_I) begin
          w_state_next = S_BIAS;
        end else begin
          w_i_next = r_i + I_ONE;
        end
      end
      S_BIAS: begin
        w_bias_read  = 1'b1;
        w_state_next = S_ADD;
      end
      S_ADD: begin
        w_bias_add   = 1'b1;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_ofm_write = 1'b1;
        if (r_n == LAST_N) begin
          w_state_next = S_DONE;
        end else begin
          w_n_next     = r_n + N_ONE;
          w_state_next = S_CLEAR;
        end
      end
      S_DONE: begin
        w_start_to_next = 1'b1;
        w_state_next    = seq.end_from_next ? S_IDLE : S_WAIT_NEXT;
      end
      S_WAIT_NEXT: begin
        if (seq.end_from_next) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign seq.end_to_previous   = w_end_to_previous;
  assign seq.start_to_next     = w_start_to_next;
  assign seq.ifm_enable_read   = w_mac_read;
  assign seq.ifm_address_read  = r_i;
  assign seq.wm_enable_read    = w_mac_read;
  assign seq.wm_address_read   = r_w;
  assign seq.bias_enable_read  = w_bias_read;
  assign seq.bias_address_read = r_n;
  assign seq.acc_clear         = w_acc_clear;
  assign seq.acc_enable        = r_acc_enable;
  assign seq.bias_add          = w_bias_add;
  assign seq.ofm_enable_write  = w_ofm_write;
  assign seq.ofm_address_write = r_n;
  assign seq.busy              = (r_state != S_IDLE);

endmodule
